pipe_skid_latch: RTL and testbench

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

---
 rtl/pipe_skid_latch.sv | 103 ++++++++++
 tb/tb_pipe_skid_latch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: two-entry valid/ready pipeline stage (main register plus
// one skid register) that decouples in_ready from out_ready so that the
// upstream ready path is fully registered, while still sustaining one beat
// per cycle when the downstream side is not stalling.
module pipe_skid_latch #(
    parameter int WIDTH          = 102,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;
    logic [1:0]       count_q;
    logic             accept;
    logic             emit;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign count     = count_q;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid & out_ready;

    // Next-state and datapath selection; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && emit) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = S_TWO;
                end else if (emit) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (emit) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = S_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end
    end

    // State, payload and the registered in_ready/count views of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != S_TWO);
            count_q    <= (state_d == S_TWO) ? 2'd2 :
                          (state_d == S_ONE) ? 2'd1 : 2'd0;
        end
    end

endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb_pipe_skid_latch: directed and randomized checks of pipe_skid_latch
// against a queue-based reference model of the held beats.
module tb_pipe_skid_latch;

    localparam int W = 102;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   count;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: the queue holds the beats the block must currently own,
    // oldest first; its head is what out_data must show.
    logic [W-1:0] mq[$];
    bit           m_in_ready = 1'b0;
    bit           m_zero     = 1'b1;
    bit           m_acc;
    bit           stall_now  = 1'b0;
    logic [W-1:0] prev_data  = '0;

    pipe_skid_latch #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_output(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then wait for the next falling edge.
    task automatic apply_stimulus(input bit v, input logic [W-1:0] d, input bit rdy, input bit fl);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
    endtask

    // Advance the model on each edge (or reset), then compare the DUT 1 unit later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_in_ready = 1'b0;
            m_zero     = 1'b1;
            stall_now  = 1'b0;
        end else begin
            stall_now = out_valid && !out_ready && !flush;
            m_acc     = in_valid && m_in_ready;
            if (flush) begin
                mq.delete();
                m_zero     = 1'b1;
                m_in_ready = 1'b1;
            end else begin
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (m_acc) begin
                    mq.push_back(in_data);
                    m_zero = 1'b0;
                end
                m_in_ready = (mq.size() < 2);
            end
        end
        #1;
        check_output("model_out_valid", W'(out_valid), W'(mq.size() != 0));
        check_output("model_count", W'(count), W'(mq.size()));
        check_output("model_in_ready", W'(in_ready), W'(m_in_ready));
        if (mq.size() != 0)
            check_output("model_out_data", out_data, mq[0]);
        else if (m_zero)
            check_output("model_out_data_zero", out_data, '0);
        if (stall_now)
            check_output("stall_hold", out_data, prev_data);
        prev_data = out_data;
    end

    logic [W-1:0] lit;
    logic [31:0]  r0, r1, r2, r3;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_in_ready", W'(in_ready), '0);
        check_output("rst_out_valid", W'(out_valid), '0);
        check_output("rst_count", W'(count), '0);
        check_output("rst_out_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);
        check_output("post_rst_in_ready", W'(in_ready), W'(1));

        // Single beat through an empty stage.
        lit = 102'h1_2345678_9ABCDEF0;
        apply_stimulus(1'b1, lit, 1'b1, 1'b0);
        check_output("single_valid", W'(out_valid), W'(1));
        check_output("single_data", out_data, lit);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("single_drain", W'(out_valid), '0);

        // Backpressure: A and B fill the stage, C waits upstream.
        apply_stimulus(1'b1, W'(32'hA), 1'b0, 1'b0);
        check_output("bp_count1", W'(count), W'(1));
        apply_stimulus(1'b1, W'(32'hB), 1'b0, 1'b0);
        check_output("bp_count2", W'(count), W'(2));
        check_output("bp_in_ready", W'(in_ready), '0);
        apply_stimulus(1'b1, W'(32'hC), 1'b0, 1'b0);
        check_output("bp_hold_a", out_data, W'(32'hA));
        apply_stimulus(1'b1, W'(32'hC), 1'b1, 1'b0);
        check_output("bp_out_b", out_data, W'(32'hB));
        apply_stimulus(1'b1, W'(32'hC), 1'b1, 1'b0);
        check_output("bp_out_c", out_data, W'(32'hC));
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("bp_drained", W'(out_valid), '0);

        // Streaming: a beat in and a beat out every cycle.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, W'(100 + i), 1'b1, 1'b0);
            check_output("stream_data", out_data, W'(100 + i));
            check_output("stream_count", W'(count), W'(1));
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush while holding two beats with an offered beat.
        apply_stimulus(1'b1, W'(32'hD1), 1'b0, 1'b0);
        apply_stimulus(1'b1, W'(32'hD2), 1'b0, 1'b0);
        apply_stimulus(1'b1, W'(32'hD3), 1'b1, 1'b1);
        check_output("flush_count", W'(count), '0);
        check_output("flush_valid", W'(out_valid), '0);
        check_output("flush_data", out_data, '0);
        check_output("flush_in_ready", W'(in_ready), W'(1));
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("flush_gone", W'(out_valid), '0);

        // Asynchronous reset pulse between edges while holding two beats.
        apply_stimulus(1'b1, W'(32'hE1), 1'b0, 1'b0);
        apply_stimulus(1'b1, W'(32'hE2), 1'b0, 1'b0);
        in_valid = 1'b0;
        check_output("pre_rst_count", W'(count), W'(2));
        #2 reset = 1'b1;
        #1;
        check_output("async_valid", W'(out_valid), '0);
        check_output("async_count", W'(count), '0);
        check_output("async_data", out_data, '0);
        check_output("async_in_ready", W'(in_ready), '0);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("async_in_ready_rise", W'(in_ready), W'(1));
        check_output("async_count_after", W'(count), '0);

        // Randomized valid/ready/flush traffic checked by the model process.
        for (int i = 0; i < 10000; i++) begin
            r0 = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            r3 = $urandom;
            apply_stimulus($urandom_range(0, 3) != 0, {r3[5:0], r2, r1, r0},
                           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
